// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and data_mem_responder.
// Signal suffixes are named from the responder's side of the link.
interface data_mem_responder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      input  rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
      output rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one byte/half/word load or store at a time,
// with a fixed number of wait states between accept and response.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic               clk,
   input  logic               rst,
   data_mem_responder_if.slave bus
);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;

   logic             accept;
   logic             access_en;
   logic             access_err;
   logic             wr_en;
   logic             rd_en;
   logic [IDX_W-1:0] idx;
   logic [3:0]       be;
   logic [31:0]      wdata_lane;
   logic [31:0]      rd_word;
   logic             cur_err;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      load_val;

   function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
      logic f;
      f = (size == 2'b11)
         || (size == 2'b01 && addr[0])
         || (size == 2'b10 && addr[1:0] != 2'b00)
         || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
      return f;
   endfunction

   assign accept = bus.req_valid_i && (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we_i;
               addr_d  = bus.req_addr_i;
               wdata_d = bus.req_wdata_i;
               size_d  = bus.req_size_i;
               uns_d   = bus.req_unsigned_i;
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (bus.rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
      end
   end

   // The array is touched only on the edge entering RESP, using the request as it will be captured.
   assign access_en  = (state_d == RESP) && (state_q != RESP) && !rst;
   assign access_err = access_fault(addr_d, size_d);
   assign wr_en      = access_en && we_d && !access_err;
   assign rd_en      = access_en && !we_d && !access_err;
   assign idx        = addr_d[IDX_W+1:2];

   always_comb begin
      be         = 4'b0000;
      wdata_lane = wdata_d;
      case (size_d)
         2'b00: begin
            be[addr_d[1:0]] = 1'b1;
            wdata_lane      = {4{wdata_d[7:0]}};
         end
         2'b01: begin
            be         = addr_d[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata_d[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH_WORDS];
         logic [7:0] rd_q;
         always_ff @(posedge clk) begin
            if (wr_en && be[gi]) mem_q[idx] <= wdata_lane[gi*8 +: 8];
            if (rd_en)           rd_q       <= mem_q[idx];
         end
         assign rd_word[gi*8 +: 8] = rd_q;
      end
   endgenerate

   assign cur_err = access_fault(addr_q, size_q);
   assign ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
   assign ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_val = rd_word;
      case (size_q)
         2'b00:   load_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_val = rd_word;
      endcase
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = (state_q == RESP);
   assign bus.rsp_err_o   = (state_q == RESP) && cur_err;
   assign bus.rsp_rdata_o = ((state_q == RESP) && !we_q && !cur_err) ? load_val : 32'd0;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_STATES, default 1, cycles inserted between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request can be accepted.
REQ-007 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 SHALL have port req_unsigned_i  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port rsp_valid_o  output  1  response present.
REQ-013 SHALL have port rsp_ready_i  input  1  requester accepts response.
REQ-014 SHALL have port rsp_rdata_o  output  32  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o  output  1  access faulted (misaligned, out of range, reserved size).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid_i & req_ready_o in IDLE, capturing we, addr, wdata, size, unsigned into internal registers.
REQ-018 On accept, SHALL go to WAIT with counter = WAIT_STATES-1 when WAIT_STATES>0, else directly to RESP.
REQ-019 In WAIT, SHALL decrement counter each cycle and go to RESP on the cycle counter is 0.
REQ-020 SHALL perform the memory access (store write / load read) on the transition into RESP; response latency = WAIT_STATES+1 cycles after accept.
REQ-021 In RESP, SHALL hold rsp_valid_o=1 and rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1, then return to IDLE next cycle; no accept in the handshake cycle.
REQ-022 SHALL flag error when size=11, when size=01 and addr[0]=1, when size=10 and addr[1:0]!=0, or when addr[31:2] >= DEPTH_WORDS.
REQ-023 On error SHALL not modify storage and SHALL return rsp_rdata_o=0, rsp_err_o=1.
REQ-024 Byte store SHALL write wdata[7:0] into lane addr[1:0] only; half store writes wdata[15:0] into lanes {addr[1],0}..+1; word store writes all four lanes; other lanes unchanged.
REQ-025 Byte load SHALL extract lane addr[1:0]; half load extracts half addr[1]; extend per req_unsigned_i; word load ignores req_unsigned_i.
REQ-026 Storage SHALL be little-endian: lane 0 = bits [7:0].
REQ-027 Store responses SHALL return rsp_rdata_o=0, rsp_err_o=0.
REQ-028 Request inputs outside the accept cycle SHALL be ignored.

Reset
REQ-029 On rst SHALL enter IDLE, clear counter and captured registers; req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 the cycle after rst.
REQ-030 rst during WAIT SHALL abandon the pending request; a pending store SHALL not be written.
REQ-031 rst SHALL not clear storage contents.

Verification
REQ-032 WAIT_STATES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid_o 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 After REQ-032: SB addr 0x11 data 0x80; LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-034 LH addr 0x12 signed -> 0xFFFFDEAD; LH addr 0x13 -> err 1, rdata 0; SW addr 0x12 -> err 1, LW 0x10 still 0xDEAD80EF.
REQ-035 LW addr 4*DEPTH_WORDS -> err 1; size=11 -> err 1; no storage change.
REQ-036 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o, rdata, err stable, req_ready_o=0; release -> IDLE next cycle.
REQ-037 WAIT_STATES=3: SW 0x20 data 0x12345678, assert rst during WAIT -> IDLE, outputs 0; subsequent LW 0x20 returns prior contents, not 0x12345678.
